// File: rtl/fpu_pkg.sv
// Shared op codes, sequencer states and per-op latencies for the FPU sequencer.
// FPU_SEQ_FAST_COMB_EN shortens neg/abs/slt to a single cycle.
package fpu_pkg;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_MUL   = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_NEG   = 4'd4;
   localparam logic [3:0] OP_ABS   = 4'd5;
   localparam logic [3:0] OP_SQRT  = 4'd6;
   localparam logic [3:0] OP_SLT   = 4'd7;
   localparam logic [3:0] OP_ITOF  = 4'd8;
   localparam logic [3:0] OP_FTOI  = 4'd9;
   localparam logic [3:0] OP_FLOOR = 4'd10;

   localparam logic [2:0] LAT_ARITH     = 3'd2;
   localparam logic [2:0] LAT_ITERATIVE = 3'd4;
   localparam logic [2:0] LAT_ILLEGAL   = 3'd1;
`ifdef FPU_SEQ_FAST_COMB_EN
   localparam logic [2:0] LAT_COMB      = 3'd1;
`else
   localparam logic [2:0] LAT_COMB      = 3'd2;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic op_is_legal(input logic [3:0] op);
      return (op <= OP_FLOOR);
   endfunction

endpackage

// File: rtl/fpu_lat_lut.sv
// Combinational op-code to latency lookup with an illegal-op flag.
// Latency of neg/abs/slt follows FPU_SEQ_FAST_COMB_EN through fpu_pkg.
import fpu_pkg::*;

module fpu_lat_lut (
   input  logic [3:0] op_i,
   output logic [2:0] lat_o,
   output logic       illegal_o
);

   always_comb begin
      lat_o     = LAT_ILLEGAL;
      illegal_o = !op_is_legal(op_i);
      case (op_i)
         OP_ADD, OP_SUB, OP_MUL,
         OP_ITOF, OP_FTOI, OP_FLOOR: lat_o = LAT_ARITH;
         OP_DIV, OP_SQRT:            lat_o = LAT_ITERATIVE;
         OP_NEG, OP_ABS, OP_SLT:     lat_o = LAT_COMB;
         default:                    lat_o = LAT_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/fpu_sequencer.sv
// Single-outstanding FPU issue sequencer: latches an op, waits its latency, returns the result.
// Build option FPU_SEQ_FAST_COMB_EN (see fpu_pkg) shortens neg/abs/slt latency.
import fpu_pkg::*;

module fpu_sequencer (
   input  logic        clk,
   input  logic        rstn,
   input  logic        issue_valid,
   output logic        issue_ready,
   input  logic [3:0]  issue_op,
   input  logic [4:0]  issue_tag,
   input  logic [31:0] issue_a,
   input  logic [31:0] issue_b,
   output logic [3:0]  fpu_control,
   output logic [31:0] fpu_srcA,
   output logic [31:0] fpu_srcB,
   input  logic [31:0] fpu_result_in,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic [4:0]  res_tag,
   output logic        busy,
   output logic        illegal_op,
   output logic [1:0]  dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
   // issue_ready is 1 only in IDLE; res_valid stays high with stable data until res_ready.
   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        res_valid_q, res_valid_d;
   logic        illegal_q, illegal_d;
   logic        op_bad_q, op_bad_d;
   logic [31:0] res_data_q, res_data_d;
   logic [4:0]  res_tag_q, res_tag_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [31:0] src_a_q, src_a_d;
   logic [31:0] src_b_q, src_b_d;

   logic [2:0]  lut_lat;
   logic        lut_illegal;

   fpu_lat_lut u_lat_lut (
      .op_i      (issue_op),
      .lat_o     (lut_lat),
      .illegal_o (lut_illegal)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         res_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
         op_bad_q    <= 1'b0;
         res_data_q  <= 32'h0;
         res_tag_q   <= 5'd0;
         ctrl_q      <= 4'b0000;
         src_a_q     <= 32'h0;
         src_b_q     <= 32'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         res_valid_q <= res_valid_d;
         illegal_q   <= illegal_d;
         op_bad_q    <= op_bad_d;
         res_data_q  <= res_data_d;
         res_tag_q   <= res_tag_d;
         ctrl_q      <= ctrl_d;
         src_a_q     <= src_a_d;
         src_b_q     <= src_b_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      res_valid_d = res_valid_q;
      illegal_d   = 1'b0;
      op_bad_d    = op_bad_q;
      res_data_d  = res_data_q;
      res_tag_d   = res_tag_q;
      ctrl_d      = ctrl_q;
      src_a_d     = src_a_q;
      src_b_d     = src_b_q;

      case (state_q)
         ST_IDLE: begin
            if (issue_valid) begin
               state_d   = ST_EXEC;
               cnt_d     = lut_lat;
               ctrl_d    = issue_op;
               res_tag_d = issue_tag;
               src_a_d   = issue_a;
               src_b_d   = issue_b;
               op_bad_d  = lut_illegal;
               illegal_d = lut_illegal;
            end
         end
         ST_EXEC: begin
            cnt_d = cnt_q - 3'd1;
            // The datapath result is only trusted on the final count.
            if (cnt_q == 3'd1) begin
               state_d     = ST_RESP;
               res_valid_d = 1'b1;
               res_data_d  = op_bad_q ? 32'h0 : fpu_result_in;
            end
         end
         ST_RESP: begin
            if (res_ready) begin
               state_d     = ST_IDLE;
               res_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            res_valid_d = 1'b0;
         end
      endcase
   end

   assign issue_ready = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign dbg_state   = state_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign res_tag     = res_tag_q;
   assign illegal_op  = illegal_q;
   assign fpu_control = ctrl_q;
   assign fpu_srcA    = src_a_q;
   assign fpu_srcB    = src_b_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed, table-driven bench for fpu_sequencer with a small behavioural FPU model.
module tb_fpu_sequencer;

   logic        clk = 1'b0;
   logic        rstn;
   logic        issue_valid;
   logic        issue_ready;
   logic [3:0]  issue_op;
   logic [4:0]  issue_tag;
   logic [31:0] issue_a;
   logic [31:0] issue_b;
   logic [3:0]  fpu_control;
   logic [31:0] fpu_srcA;
   logic [31:0] fpu_srcB;
   logic [31:0] fpu_result_in;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic [4:0]  res_tag;
   logic        busy;
   logic        illegal_op;
   logic [1:0]  dbg_state;

`ifdef FPU_SEQ_FAST_COMB_EN
   localparam int FAST_L = 1;
`else
   localparam int FAST_L = 2;
`endif

   typedef struct {
      logic [3:0]  op;
      logic [4:0]  tag;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] data;
      int          lat;
      logic        ill;
   } vec_t;

   vec_t vecs [14];
   int   n_checks = 0;
   int   n_fail   = 0;

   fpu_sequencer dut (
      .clk           (clk),
      .rstn          (rstn),
      .issue_valid   (issue_valid),
      .issue_ready   (issue_ready),
      .issue_op      (issue_op),
      .issue_tag     (issue_tag),
      .issue_a       (issue_a),
      .issue_b       (issue_b),
      .fpu_control   (fpu_control),
      .fpu_srcA      (fpu_srcA),
      .fpu_srcB      (fpu_srcB),
      .fpu_result_in (fpu_result_in),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_data      (res_data),
      .res_tag       (res_tag),
      .busy          (busy),
      .illegal_op    (illegal_op),
      .dbg_state     (dbg_state)
   );

   always #5 clk = ~clk;

   // Stand-in FPU: exact IEEE answers for the documented vectors, a bit-mix otherwise.
   function automatic logic [31:0] fpu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [31:0] r;
      r = {a[15:0], b[15:0]} ^ {28'h0, op};
      case (op)
         4'd0: if (a == 32'h3F800000 && b == 32'h40000000) r = 32'h40400000;
         4'd3: if (a == 32'h3F800000 && b == 32'h40000000) r = 32'h3F000000;
         4'd4: r = b ^ 32'h80000000;
         4'd5: r = b & 32'h7FFFFFFF;
         default: ;
      endcase
      return r;
   endfunction

   always_comb fpu_result_in = fpu_model(fpu_control, fpu_srcA, fpu_srcB);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Waits up to 20 edges for res_valid; returns cycles since acceptance and side flags.
   task automatic wait_result(output int cyc, output logic saw_ill, output logic saw_rdy);
      cyc     = 0;
      saw_ill = 1'b0;
      saw_rdy = 1'b0;
      while (!res_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (illegal_op) saw_ill = 1'b1;
         if (issue_ready) saw_rdy = 1'b1;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int   cyc;
      logic saw_ill, saw_rdy;
      @(negedge clk);
      issue_valid = 1'b1;
      issue_op    = v.op;
      issue_tag   = v.tag;
      issue_a     = v.a;
      issue_b     = v.b;
      @(posedge clk); #1;
      check("accept_busy", {31'b0, busy}, 32'd1);
      check("illegal_pulse", {31'b0, illegal_op}, {31'b0, v.ill});
      check("no_early_valid", {31'b0, res_valid}, 32'd0);
      // Garbage request while busy must be ignored.
      @(negedge clk);
      issue_valid = 1'b1;
      issue_op    = 4'hE;
      issue_tag   = ~v.tag;
      issue_a     = $urandom;
      issue_b     = $urandom;
      wait_result(cyc, saw_ill, saw_rdy);
      check("latency", cyc, v.lat);
      check("res_data", res_data, v.data);
      check("res_tag", {27'b0, res_tag}, {27'b0, v.tag});
      check("ctrl_held", {28'b0, fpu_control}, {28'b0, v.op});
      check("srcA_held", fpu_srcA, v.a);
      check("srcB_held", fpu_srcB, v.b);
      check("illegal_one_cycle", {31'b0, saw_ill}, 32'd0);
      check("ready_low_busy", {31'b0, saw_rdy}, 32'd0);
      @(negedge clk);
      issue_valid = 1'b0;
      @(posedge clk); #1;
      check("valid_drop", {31'b0, res_valid}, 32'd0);
      check("ready_back", {31'b0, issue_ready}, 32'd1);
   endtask

   initial begin
      int   cyc;
      logic saw_ill, saw_rdy;

      vecs[0]  = '{4'd0,  5'd3,  32'h3F800000, 32'h40000000, 32'h40400000, 2,        1'b0};
      vecs[1]  = '{4'd1,  5'd10, 32'h12345678, 32'h9ABCDEF0, 32'h5678DEF1, 2,        1'b0};
      vecs[2]  = '{4'd2,  5'd31, 32'hAAAA1111, 32'hBBBB2222, 32'h11112220, 2,        1'b0};
      vecs[3]  = '{4'd3,  5'd4,  32'h3F800000, 32'h40000000, 32'h3F000000, 4,        1'b0};
      vecs[4]  = '{4'd4,  5'd5,  32'h00000000, 32'h3F800000, 32'hBF800000, FAST_L,   1'b0};
      vecs[5]  = '{4'd5,  5'd6,  32'h00000000, 32'hC0490FDB, 32'h40490FDB, FAST_L,   1'b0};
      vecs[6]  = '{4'd6,  5'd8,  32'h40800000, 32'h00000000, 32'h00000006, 4,        1'b0};
      vecs[7]  = '{4'd7,  5'd9,  32'h00010002, 32'h00030004, 32'h00020003, FAST_L,   1'b0};
      vecs[8]  = '{4'd8,  5'd0,  32'h0000FFFF, 32'hFFFF0000, 32'hFFFF0008, 2,        1'b0};
      vecs[9]  = '{4'd9,  5'd1,  32'h00000001, 32'h00000002, 32'h0001000B, 2,        1'b0};
      vecs[10] = '{4'd10, 5'd2,  32'hCAFE0000, 32'h0000BEEF, 32'h0000BEE5, 2,        1'b0};
      vecs[11] = '{4'hC,  5'd7,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1,        1'b1};
      vecs[12] = '{4'hF,  5'd30, 32'h3F800000, 32'h40000000, 32'h00000000, 1,        1'b1};
      vecs[13] = '{4'hB,  5'd17, 32'h0000A5A5, 32'h00005A5A, 32'h00000000, 1,        1'b1};

      rstn        = 1'b0;
      issue_valid = 1'b0;
      issue_op    = 4'd0;
      issue_tag   = 5'd0;
      issue_a     = 32'h0;
      issue_b     = 32'h0;
      res_ready   = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_issue_ready", {31'b0, issue_ready}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_res_valid", {31'b0, res_valid}, 32'd0);
      check("rst_illegal", {31'b0, illegal_op}, 32'd0);
      check("rst_ctrl", {28'b0, fpu_control}, 32'd0);
      check("rst_srcA", fpu_srcA, 32'd0);
      check("rst_srcB", fpu_srcB, 32'd0);
      check("rst_res_data", res_data, 32'd0);
      check("rst_res_tag", {27'b0, res_tag}, 32'd0);
      check("rst_state", {30'b0, dbg_state}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 14; i++) run_vec(vecs[i]);

      // Backpressure: result held, queued request waits for the handshake edge to pass.
      @(negedge clk);
      res_ready   = 1'b0;
      issue_valid = 1'b1;
      issue_op    = 4'd0;
      issue_tag   = 5'd9;
      issue_a     = 32'h3F800000;
      issue_b     = 32'h40000000;
      @(posedge clk); #1;
      check("bp_accept", {31'b0, busy}, 32'd1);
      @(negedge clk);
      issue_op  = 4'd2;
      issue_tag = 5'd12;
      issue_a   = 32'h00001234;
      issue_b   = 32'h00005678;
      wait_result(cyc, saw_ill, saw_rdy);
      check("bp_latency", cyc, 2);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("bp_valid_hold", {31'b0, res_valid}, 32'd1);
         check("bp_data_hold", res_data, 32'h40400000);
         check("bp_tag_hold", {27'b0, res_tag}, 32'd9);
         check("bp_ready_low", {31'b0, issue_ready}, 32'd0);
         check("bp_ctrl_hold", {28'b0, fpu_control}, 32'd0);
      end
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_handshake_valid", {31'b0, res_valid}, 32'd0);
      check("bp_no_same_edge_accept", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      check("bp_second_accept", {31'b0, busy}, 32'd1);
      check("bp_second_ctrl", {28'b0, fpu_control}, 32'd2);
      check("bp_second_tag", {27'b0, res_tag}, 32'd12);
      @(negedge clk);
      issue_valid = 1'b0;
      wait_result(cyc, saw_ill, saw_rdy);
      check("bp_second_latency", cyc, 2);
      check("bp_second_data", res_data, 32'h1234567A);
      @(posedge clk); #1;
      check("bp_second_drop", {31'b0, res_valid}, 32'd0);

      // Reset two edges into a divide discards it; reset also beats a pending request.
      @(negedge clk);
      issue_valid = 1'b1;
      issue_op    = 4'd3;
      issue_tag   = 5'd4;
      issue_a     = 32'h3F800000;
      issue_b     = 32'h40000000;
      @(posedge clk); #1;
      check("rst_mid_accept", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      rstn = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_idle", {30'b0, dbg_state}, 32'd0);
      check("rst_mid_valid", {31'b0, res_valid}, 32'd0);
      check("rst_mid_ctrl", {28'b0, fpu_control}, 32'd0);
      check("rst_mid_srcA", fpu_srcA, 32'd0);
      check("rst_mid_tag", {27'b0, res_tag}, 32'd0);
      @(posedge clk); #1;
      check("rst_priority", {31'b0, busy}, 32'd0);
      @(negedge clk);
      rstn        = 1'b1;
      issue_valid = 1'b0;
      saw_ill     = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (res_valid) saw_ill = 1'b1;
      end
      check("rst_no_result", {31'b0, saw_ill}, 32'd0);
      check("rst_ready_after", {31'b0, issue_ready}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
